// File: rtl/wb_regfile.sv
// Write-back stage: result select, 32-entry register file with write-through
// read bypass, committed-write counter and a registered debug read port.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_w,
    input  logic              is_lw_w,
    input  logic              is_jal_w,
    input  logic              is_mul_w,
    input  logic [ADDR_W-1:0] w_addr_w,
    input  logic [DATA_W-1:0] alu_w,
    input  logic [DATA_W-1:0] mul_w,
    input  logic [DATA_W-1:0] npc_w,
    input  logic [DATA_W-1:0] dm_rdata_w,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    always_comb begin
        if (is_jal_w) begin
            wb_data = npc_w;
        end else if (is_lw_w) begin
            wb_data = dm_rdata_w;
        end else if (is_mul_w) begin
            wb_data = mul_w;
        end else begin
            wb_data = alu_w;
        end
    end

    assign wb_we   = write_w & (w_addr_w != '0) & ~rst;
    assign wb_addr = w_addr_w;

    always_comb begin
        rdata1 = '0;
        if (rst || raddr1 == '0) begin
            rdata1 = '0;
        end else if (wb_we && raddr1 == w_addr_w) begin
            rdata1 = wb_data;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || raddr2 == '0) begin
            rdata2 = '0;
        end else if (wb_we && raddr2 == w_addr_w) begin
            rdata2 = wb_data;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

    // Entry 0 is cleared on reset and never written, so it always holds 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            dbg_data <= '0;
            wr_count <= '0;
        end else begin
            if (wb_we) begin
                regs[w_addr_w] <= wb_data;
                wr_count       <= wr_count + CNT_W'(1);
            end
            dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset, debug and
// counter-wrap sequences. Counter is built narrow so the wrap is reachable.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_w, is_lw_w, is_jal_w, is_mul_w;
    logic [AW-1:0] w_addr_w, raddr1, raddr2, dbg_addr;
    logic [DW-1:0] alu_w, mul_w, npc_w, dm_rdata_w;
    logic [DW-1:0] rdata1, rdata2, wb_data, dbg_data;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [CW-1:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .write_w(write_w), .is_lw_w(is_lw_w),
        .is_jal_w(is_jal_w), .is_mul_w(is_mul_w), .w_addr_w(w_addr_w),
        .alu_w(alu_w), .mul_w(mul_w), .npc_w(npc_w),
        .dm_rdata_w(dm_rdata_w), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .wr_count(wr_count)
    );

    typedef struct {
        logic          wr, lw, jal, mul;
        logic [AW-1:0] wa;
        logic [DW-1:0] alu, mulv, npc, dm;
        logic [AW-1:0] ra1, ra2;
        logic [DW-1:0] e_rd1, e_rd2;
        logic          e_we;
        logic [DW-1:0] e_wbd;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string nm, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_w  = 1'b0; is_lw_w = 1'b0; is_jal_w = 1'b0; is_mul_w = 1'b0;
        w_addr_w = '0; alu_w = '0; mul_w = '0; npc_w = '0; dm_rdata_w = '0;
        raddr1 = '0; raddr2 = '0;
    endtask

    task automatic wr_alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        write_w  = 1'b1;
        w_addr_w = a;
        alu_w    = d;
        step();
    endtask

    initial begin
        vt[0] = '{1,0,0,0, 5, 'h1234, 0, 0, 0, 5, 0,
                  'h1234, 0, 1, 'h1234, 1};
        vt[1] = '{0,0,0,0, 5, 0, 0, 0, 0, 5, 5,
                  'h1234, 'h1234, 0, 0, 1};
        vt[2] = '{1,0,0,0, 0, 'hFFFF, 0, 0, 0, 0, 5,
                  0, 'h1234, 0, 'hFFFF, 1};
        vt[3] = '{1,1,1,1, 31, 'h11, 'h77, 'h40, 'h99, 31, 31,
                  'h40, 'h40, 1, 'h40, 2};
        vt[4] = '{1,1,0,1, 31, 'h11, 'h77, 'h40, 'h99, 31, 5,
                  'h99, 'h1234, 1, 'h99, 3};
        vt[5] = '{1,0,0,1, 31, 'h11, 'h77, 'h40, 'h99, 31, 0,
                  'h77, 0, 1, 'h77, 4};
        vt[6] = '{0,0,0,0, 31, 'h11, 'h77, 'h40, 'h99, 31, 0,
                  'h77, 0, 0, 'h11, 4};
        vt[7] = '{1,0,0,0, 5, 'hA, 0, 0, 0, 5, 31,
                  'hA, 'h77, 1, 'hA, 5};
        vt[8] = '{0,0,0,0, 5, 0, 0, 0, 0, 5, 1,
                  'hA, 0, 0, 0, 5};

        idle();
        dbg_addr = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Fill the file, then a single reset cycle must clear everything.
        for (int i = 1; i < 32; i++) begin
            wr_alu(AW'(i), DW'(i * 3 + 1));
        end
        idle();
        raddr1 = 10;
        #1;
        check("prefill_r10", rdata1, 31);
        dbg_addr = 10;
        rst = 1'b1;
        #1;
        check("rst_rdata1", rdata1, 0);
        step();
        rst = 1'b0;
        check("rst_cnt", DW'(wr_count), 0);
        check("rst_dbg", dbg_data, 0);
        begin
            int bad = 0;
            for (int i = 1; i < 32; i++) begin
                raddr1 = AW'(i);
                raddr2 = AW'(32 - i);
                #1;
                if (rdata1 !== '0 || rdata2 !== '0) bad++;
            end
            check("rst_all_zero", DW'(bad), 0);
        end

        for (int i = 0; i < 9; i++) begin
            write_w = vt[i].wr; is_lw_w = vt[i].lw;
            is_jal_w = vt[i].jal; is_mul_w = vt[i].mul;
            w_addr_w = vt[i].wa; alu_w = vt[i].alu; mul_w = vt[i].mulv;
            npc_w = vt[i].npc; dm_rdata_w = vt[i].dm;
            raddr1 = vt[i].ra1; raddr2 = vt[i].ra2;
            #1;
            check($sformatf("v%0d_rd1", i), rdata1, vt[i].e_rd1);
            check($sformatf("v%0d_rd2", i), rdata2, vt[i].e_rd2);
            check($sformatf("v%0d_we", i), DW'(wb_we), DW'(vt[i].e_we));
            check($sformatf("v%0d_wbd", i), wb_data, vt[i].e_wbd);
            check($sformatf("v%0d_wba", i), DW'(wb_addr), DW'(vt[i].wa));
            step();
            check($sformatf("v%0d_cnt", i), DW'(wr_count), DW'(vt[i].e_cnt));
        end

        // Debug port: old array value when written the same cycle.
        wr_alu(5, 'hBEEF);
        dbg_addr = 5;
        wr_alu(5, 'hCAFE);
        check("dbg_old", dbg_data, 'hBEEF);
        idle();
        step();
        check("dbg_new", dbg_data, 'hCAFE);
        dbg_addr = 0;
        step();
        check("dbg_r0", dbg_data, 0);
        dbg_addr = 31;
        step();
        check("dbg_r31", dbg_data, 'h77);

        // Reset wins over a write presented in the same cycle.
        idle();
        rst = 1'b1;
        write_w = 1'b1; w_addr_w = 7; alu_w = 'h55; raddr1 = 7; raddr2 = 5;
        #1;
        check("rstw_rd1", rdata1, 0);
        check("rstw_rd2", rdata2, 0);
        check("rstw_we", DW'(wb_we), 0);
        step();
        rst = 1'b0;
        idle();
        raddr1 = 7;
        #1;
        check("rstw_r7", rdata1, 0);
        check("rstw_cnt", DW'(wr_count), 0);

        // Counter wrap: 15 writes reach the max, one more returns to 0.
        for (int i = 0; i < 15; i++) begin
            wr_alu(3, DW'(i));
        end
        check("cnt_max", DW'(wr_count), 15);
        wr_alu(3, 'h3C);
        check("cnt_wrap", DW'(wr_count), 0);
        idle();
        raddr1 = 3;
        #1;
        check("wrap_r3", rdata1, 'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
